// File: rtl/bin2seg_codes.sv
// Signed binary to seven-segment display codes via sequential double-dabble.
// One magnitude bit per clock; digits update only on completion, blanking and sign placed at the end.
module bin2seg_codes #(
    parameter int WIDTH         = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [4:0]       digit3,
    output logic [4:0]       digit2,
    output logic [4:0]       digit1,
    output logic [4:0]       digit0
);

    localparam logic [4:0] C_E     = 5'h0E;
    localparam logic [4:0] C_R     = 5'h14;
    localparam logic [4:0] C_NEG   = 5'h16;
    localparam logic [4:0] C_BLANK = 5'h17;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FORMAT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // r_bcd[18:16] is the ten-thousands digit: at most 6 for a 16-bit magnitude
    logic [18:0]      r_bcd;
    logic [WIDTH-1:0] r_mag;
    logic             r_neg;
    logic             r_ovf;
    logic [4:0]       r_cnt;
    logic             r_done;
    logic [4:0]       r_dig3, r_dig2, r_dig1, r_dig0;

    logic             w_neg;
    logic [WIDTH-1:0] w_mag;
    logic [16:0]      w_mag_ext;
    logic             w_ovf_in;
    logic [15:0]      w_adj;

    // ---------------- input capture ----------------
    assign w_neg     = value[WIDTH-1];
    assign w_mag     = w_neg ? ((~value) + {{(WIDTH-1){1'b0}}, 1'b1}) : value;
    assign w_mag_ext = 17'(w_mag);
    assign w_ovf_in  = w_neg ? (w_mag_ext > 17'd999) : (w_mag_ext > 17'd9999);

    // Add-3 on the four low BCD digits; the top digit never reaches 5 before its last shift
    for (genvar g = 0; g < 4; g++) begin : g_adj
        assign w_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ? (r_bcd[g*4 +: 4] + 4'd3)
                                                           : r_bcd[g*4 +: 4];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == 5'd1) w_next = S_FORMAT;
            S_FORMAT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- shift datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd <= '0;
            r_mag <= '0;
            r_neg <= 1'b0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_bcd <= '0;
            r_mag <= w_mag;
            r_neg <= w_neg;
            r_ovf <= w_ovf_in;
            r_cnt <= 5'(WIDTH);
        end else if (r_state == S_SHIFT) begin
            r_bcd <= {r_bcd[17:16], w_adj, r_mag[WIDTH-1]};
            r_mag <= {r_mag[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // ---------------- formatting ----------------
    logic [3:0]  w_d3, w_d2, w_d1, w_d0;
    logic        w_b3, w_b2, w_b1;
    logic        w_ovf;
    logic [19:0] w_fmt;

    assign w_d3  = r_bcd[15:12];
    assign w_d2  = r_bcd[11:8];
    assign w_d1  = r_bcd[7:4];
    assign w_d0  = r_bcd[3:0];
    // A non-zero ten-thousands digit can only coincide with ovf, kept as a safety net
    assign w_ovf = r_ovf | (r_bcd[18:16] != 3'd0);

    // w_bN: digit N and everything left of it is a leading zero
    assign w_b3 = (w_d3 == 4'd0);
    assign w_b2 = w_b3 && (w_d2 == 4'd0);
    assign w_b1 = w_b2 && (w_d1 == 4'd0);

    always_comb begin
        w_fmt = {C_BLANK, C_BLANK, C_BLANK, C_BLANK};
        if (w_ovf) begin
            w_fmt = {C_E, C_R, C_R, C_BLANK};
        end else if (BLANK_LEADING) begin
            // NEG takes the first blanked slot left of the most significant digit
            w_fmt[19:15] = w_b3 ? ((r_neg && !w_b2) ? C_NEG : C_BLANK) : {1'b0, w_d3};
            w_fmt[14:10] = w_b2 ? ((r_neg && !w_b1) ? C_NEG : C_BLANK) : {1'b0, w_d2};
            w_fmt[9:5]   = w_b1 ? (r_neg ? C_NEG : C_BLANK)            : {1'b0, w_d1};
            w_fmt[4:0]   = {1'b0, w_d0};
        end else begin
            w_fmt[19:15] = r_neg ? C_NEG : {1'b0, w_d3};
            w_fmt[14:10] = {1'b0, w_d2};
            w_fmt[9:5]   = {1'b0, w_d1};
            w_fmt[4:0]   = {1'b0, w_d0};
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_dig3 <= C_BLANK;
            r_dig2 <= C_BLANK;
            r_dig1 <= C_BLANK;
            r_dig0 <= C_BLANK;
        end else begin
            r_done <= (r_state == S_FORMAT);
            if (r_state == S_FORMAT) begin
                r_dig3 <= w_fmt[19:15];
                r_dig2 <= w_fmt[14:10];
                r_dig1 <= w_fmt[9:5];
                r_dig0 <= w_fmt[4:0];
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign digit3 = r_dig3;
    assign digit2 = r_dig2;
    assign digit1 = r_dig1;
    assign digit0 = r_dig0;

endmodule

// File: tb/tb_bin2seg_codes.sv
// Directed bench for bin2seg_codes: two instances (blanking on/off) share clock and stimulus.
module tb_bin2seg_codes;

    localparam logic [4:0] B = 5'h17;
    localparam logic [4:0] N = 5'h16;
    localparam logic [4:0] E = 5'h0E;
    localparam logic [4:0] R = 5'h14;
    localparam logic [19:0] ERR = {E, R, R, B};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] value;
    logic        busy_a, done_a, busy_b, done_b;
    logic [4:0]  a3, a2, a1, a0, b3, b2, b1, b0;

    int n_cmp = 0;
    int n_err = 0;

    bin2seg_codes #(.WIDTH(16), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy_a), .done(done_a),
        .digit3(a3), .digit2(a2), .digit1(a1), .digit0(a0)
    );

    bin2seg_codes #(.WIDTH(16), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy_b), .done(done_b),
        .digit3(b3), .digit2(b2), .digit1(b1), .digit0(b0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference via integer arithmetic
    function automatic logic [19:0] model(input int v, input bit bl);
        int         m, k;
        bit         neg;
        logic [3:0] d [4];
        logic [4:0] o [4];
        if (v > 9999 || v < -999) return ERR;
        neg  = (v < 0);
        m    = neg ? -v : v;
        d[0] = 4'(m % 10);
        d[1] = 4'((m / 10) % 10);
        d[2] = 4'((m / 100) % 10);
        d[3] = 4'((m / 1000) % 10);
        k = -1;
        for (int j = 3; j >= 0; j--) if (k < 0 && d[j] != 4'd0) k = j;
        if (k < 0) k = 0;
        for (int j = 0; j < 4; j++) begin
            if (!bl)       o[j] = (neg && j == 3) ? N : {1'b0, d[j]};
            else if (j > k) o[j] = (neg && j == k + 1) ? N : B;
            else           o[j] = {1'b0, d[j]};
        end
        return {o[3], o[2], o[1], o[0]};
    endfunction

    task automatic start_conv(input logic [15:0] v);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy_a}, 32'd1);
    endtask

    // Cycles (edges) from now until done; -1 if none within 40
    task automatic wait_done(output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                lat = i;
                break;
            end
            if (busy_a) nbusy++;
        end
    endtask

    task automatic conv(input string tag, input logic [15:0] v,
                        input logic [19:0] ea, input logic [19:0] eb);
        int lat, nb;
        start_conv(v);
        wait_done(lat, nb);
        check({tag, "_lat"}, 32'(lat), 32'd17);
        check({tag, "_a"}, {12'd0, a3, a2, a1, a0}, {12'd0, ea});
        check({tag, "_b"}, {12'd0, b3, b2, b1, b0}, {12'd0, eb});
    endtask

    initial begin
        int lat, nb;
        logic [15:0] rv;

        rst = 1'b1; start = 1'b0; value = '0;
        #1;
        check("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
        check("rst_done", {30'd0, done_a, done_b}, 32'd0);
        check("rst_dig_a", {12'd0, a3, a2, a1, a0}, {12'd0, B, B, B, B});
        check("rst_dig_b", {12'd0, b3, b2, b1, b0}, {12'd0, B, B, B, B});
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // basic conversion with latency and busy length
        start_conv(16'd1234);
        wait_done(lat, nb);
        check("t1_lat", 32'(lat), 32'd17);
        check("t1_busy_cycles", 32'(nb + 1), 32'd17);
        check("t1_dig", {12'd0, a3, a2, a1, a0}, {12'd0, 5'd1, 5'd2, 5'd3, 5'd4});
        @(posedge clk); #1;
        check("t1_done_pulse", {31'd0, done_a}, 32'd0);

        conv("m5",    16'hFFFB, {B, B, N, 5'd5},        {N, 5'd0, 5'd0, 5'd5});
        conv("zero",  16'd0,    {B, B, B, 5'd0},        {5'd0, 5'd0, 5'd0, 5'd0});
        conv("9999",  16'd9999, {5'd9, 5'd9, 5'd9, 5'd9}, {5'd9, 5'd9, 5'd9, 5'd9});
        conv("10000", 16'd10000, ERR, ERR);
        conv("m1000", 16'hFC18, ERR, ERR);
        conv("m32768", 16'h8000, ERR, ERR);
        conv("32767", 16'h7FFF, ERR, ERR);
        conv("m999",  16'hFC19, {N, 5'd9, 5'd9, 5'd9}, {N, 5'd9, 5'd9, 5'd9});
        conv("m42",   16'hFFD6, {B, N, 5'd4, 5'd2},    {N, 5'd0, 5'd4, 5'd2});
        conv("1000",  16'd1000, {5'd1, 5'd0, 5'd0, 5'd0}, {5'd1, 5'd0, 5'd0, 5'd0});
        conv("105",   16'd105,  {B, 5'd1, 5'd0, 5'd5}, {5'd0, 5'd1, 5'd0, 5'd5});
        conv("m100",  16'hFF9C, {N, 5'd1, 5'd0, 5'd0}, {N, 5'd1, 5'd0, 5'd0});

        // start while busy is ignored; start in the done cycle is accepted
        start_conv(16'd42);
        repeat (4) @(posedge clk);
        @(negedge clk);
        value = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, nb);
        check("t4_lat_ignored", 32'(lat), 32'd12);
        check("t4_dig42", {12'd0, a3, a2, a1, a0}, {12'd0, B, B, 5'd4, 5'd2});
        start_conv(16'd7);
        check("t4_done_cycle_accept", {31'd0, done_a}, 32'd0);
        wait_done(lat, nb);
        check("t4_lat7", 32'(lat), 32'd17);
        check("t4_dig7", {12'd0, a3, a2, a1, a0}, {12'd0, B, B, B, 5'd7});
        check("t4_dig7_b", {12'd0, b3, b2, b1, b0}, {12'd0, 5'd0, 5'd0, 5'd0, 5'd7});

        // async reset mid-conversion
        start_conv(16'd1234);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", {30'd0, busy_a, busy_b}, 32'd0);
        check("t5_done", {30'd0, done_a, done_b}, 32'd0);
        check("t5_dig", {12'd0, a3, a2, a1, a0}, {12'd0, B, B, B, B});
        @(negedge clk) rst = 1'b0;
        wait_done(lat, nb);
        check("t5_no_done", 32'(lat), 32'hFFFF_FFFF);

        // random sweep against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            rv = 16'($urandom);
            if (i % 3 == 0) rv = 16'($urandom_range(0, 2000)) - 16'd1000;
            conv("rand", rv, model(int'($signed(rv)), 1'b1), model(int'($signed(rv)), 1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
